// File: rtl/coi2_pkg.sv
// Shared types and constants for the CoI2 decimation-filter conversion sequencer.
`timescale 1ns/1ps
package coi2_pkg;

    localparam int COI2_DW        = 32;
    localparam int COI2_OSR_W     = 16;
    localparam int COI2_FLUSH_LEN = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_INTEG = 3'd2,
        S_FLUSH = 3'd3,
        S_CAPT  = 3'd4
    } coi2_state_e;

endpackage

// File: rtl/coi2_osr_counter.sv
// Oversampling down-counter: load, decrement, terminal-count flag on the last bit.
`timescale 1ns/1ps
module coi2_osr_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Flag the cycle that gates the final modulator bit.
    assign o_tc = (r_count == W'(1));

endmodule

// File: rtl/coi2_conv_ctrl.sv
// CoI2 conversion sequencer: clear, integrate osr bits, flush, capture, result handshake.
// Optional continuous mode (cont port) is enabled by defining COI2_CTRL_CONT_EN.
`timescale 1ns/1ps
module coi2_conv_ctrl
    import coi2_pkg::*;
#(
    parameter int DW    = COI2_DW,
    parameter int OSR_W = COI2_OSR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [OSR_W-1:0] i_osr,
    input  logic             i_mod_bit,
    output logic             o_flt_clr,
    output logic             o_flt_din,
    input  logic [DW-1:0]    i_flt_dout,
    output logic             o_busy,
    output logic [DW-1:0]    o_res_data,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_overrun
`ifdef COI2_CTRL_CONT_EN
    ,
    input  logic             i_cont
`endif
);

    // state | meaning
    // IDLE  | filter held clear, waiting for start
    // CLEAR | one-cycle filter clear, counter loaded with osr_q
    // INTEG | modulator bits gated into filter, counter decrementing
    // FLUSH | one zero bit so the second integrator absorbs the last first-stage value
    // CAPT  | filter output latched into the result register
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_CLEAR = S_CLEAR;
    localparam logic [2:0] ST_INTEG = S_INTEG;
    localparam logic [2:0] ST_FLUSH = S_FLUSH;
    localparam logic [2:0] ST_CAPT  = S_CAPT;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [OSR_W-1:0] r_osr_q;
    logic [OSR_W-1:0] w_osr_eff;
    logic [DW-1:0]    r_res_data;
    logic             r_res_valid;
    logic             r_overrun;
    logic             w_tc;
    logic             w_cont;

`ifdef COI2_CTRL_CONT_EN
    assign w_cont = i_cont;
`else
    assign w_cont = 1'b0;
`endif

    assign w_osr_eff = (i_osr == '0) ? OSR_W'(1) : i_osr;

    coi2_osr_counter #(
        .W (OSR_W)
    ) u_osr_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == ST_CLEAR),
        .i_load_val (r_osr_q),
        .i_dec      (r_state == ST_INTEG),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_INTEG;
            ST_INTEG: if (w_tc) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_CAPT;
            ST_CAPT:  w_state_nxt = w_cont ? ST_CLEAR : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_osr_q     <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && i_start) begin
                r_osr_q <= w_osr_eff;
            end
            // A capture always wins over acceptance, so valid stays high on a coincident handshake.
            if (r_state == ST_CAPT) begin
                r_res_data  <= i_flt_dout;
                r_res_valid <= 1'b1;
                if (r_res_valid && !i_res_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_res_valid && i_res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign o_flt_clr   = (r_state == ST_IDLE) || (r_state == ST_CLEAR);
    assign o_flt_din   = (r_state == ST_INTEG) ? i_mod_bit : 1'b0;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_res_data  = r_res_data;
    assign o_res_valid = r_res_valid;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_coi2_conv_ctrl.sv
// Directed bench for coi2_conv_ctrl with a behavioural second-order CoI filter attached.
`timescale 1ns/1ps
module tb_coi2_conv_ctrl;

    localparam int DW    = 32;
    localparam int OSR_W = 16;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             start     = 1'b0;
    logic [OSR_W-1:0] osr       = '0;
    logic             mod_bit   = 1'b0;
    logic             res_ready = 1'b0;
`ifdef COI2_CTRL_CONT_EN
    logic             cont      = 1'b0;
`endif
    logic             flt_clr;
    logic             flt_din;
    logic             busy;
    logic             res_valid;
    logic             overrun;
    logic [DW-1:0]    flt_dout;
    logic [DW-1:0]    res_data;

    logic [DW-1:0]    integ1 = '0;
    logic [DW-1:0]    integ2 = '0;

    int tests = 0;
    int fails = 0;

    coi2_conv_ctrl #(
        .DW    (DW),
        .OSR_W (OSR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_osr       (osr),
        .i_mod_bit   (mod_bit),
        .o_flt_clr   (flt_clr),
        .o_flt_din   (flt_din),
        .i_flt_dout  (flt_dout),
        .o_busy      (busy),
        .o_res_data  (res_data),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_overrun   (overrun)
`ifdef COI2_CTRL_CONT_EN
        ,
        .i_cont      (cont)
`endif
    );

    always #5 clk = ~clk;

    // External cascade of two integrators; output is the second stage register.
    always @(posedge clk) begin
        if (flt_clr) begin
            integ1 <= '0;
            integ2 <= '0;
        end else begin
            integ1 <= integ1 + DW'(flt_din);
            integ2 <= integ2 + integ1;
        end
    end
    assign flt_dout = integ2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [OSR_W-1:0] o);
        osr   = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({flt_clr, flt_din, busy, res_valid, overrun} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 10000", {flt_clr, flt_din, busy, res_valid, overrun});
        end
        tests++;
        if (res_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %0d expected 0", res_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // osr=4, bits 1,0,1,0 -> 6; optionally pokes start (osr=7) mid-INTEG, which must be ignored.
    task automatic test_1010(input bit poke, input string tag);
        res_ready = 1'b1;
        mod_bit   = 1'b0;
        do_start(16'd4);
        tests++;
        if ({busy, flt_clr} !== 2'b11) begin
            fails++;
            $display("FAIL %s_clear: got %b expected 11", tag, {busy, flt_clr});
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            mod_bit = (c % 2 == 0);
            if (poke && c == 4) begin
                start = 1'b1;
                osr   = 16'd7;
            end else begin
                start = 1'b0;
            end
            #1;
            tests++;
            if ({flt_clr, flt_din} !== {1'b0, mod_bit}) begin
                fails++;
                $display("FAIL %s_integ_c%0d: got %b expected %b", tag, c, {flt_clr, flt_din}, {1'b0, mod_bit});
            end
        end
        tick();
        start   = 1'b0;
        mod_bit = 1'b1;
        #1;
        tests++;
        if (flt_din !== 1'b0) begin
            fails++;
            $display("FAIL %s_flush_gate: got %b expected 0", tag, flt_din);
        end
        tick();
        tests++;
        if ({busy, res_valid} !== 2'b10) begin
            fails++;
            $display("FAIL %s_capt_c7: got %b expected 10", tag, {busy, res_valid});
        end
        tick();
        tests++;
        if ({busy, res_valid} !== 2'b01 || res_data !== 32'd6) begin
            fails++;
            $display("FAIL %s_result_c8: got busy/valid %b data %0d expected 01 data 6", tag, {busy, res_valid}, res_data);
        end
        tick();
        mod_bit = 1'b0;
        tests++;
        if ({busy, res_valid} !== 2'b00) begin
            fails++;
            $display("FAIL %s_accept_c9: got %b expected 00", tag, {busy, res_valid});
        end
    endtask

    task automatic test_osr_zero();
        res_ready = 1'b1;
        mod_bit   = 1'b1;
        do_start(16'd0);
        tick();
        tick();
        tick();
        tests++;
        if ({busy, res_valid} !== 2'b10) begin
            fails++;
            $display("FAIL osr0_capt: got %b expected 10", {busy, res_valid});
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'd1) begin
            fails++;
            $display("FAIL osr0_result: got valid %b data %0d expected valid 1 data 1", res_valid, res_data);
        end
        tick();
        mod_bit = 1'b0;
    endtask

    task automatic test_accept_at_capt();
        res_ready = 1'b0;
        mod_bit   = 1'b1;
        do_start(16'd4);
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'd10) begin
            fails++;
            $display("FAIL hold_first: got valid %b data %0d expected valid 1 data 10", res_valid, res_data);
        end
        do_start(16'd1);
        tick();
        tick();
        tick();
        tests++;
        if ({busy, res_valid} !== 2'b11) begin
            fails++;
            $display("FAIL pending_at_capt: got %b expected 11", {busy, res_valid});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++;
        if ({res_valid, overrun} !== 2'b10 || res_data !== 32'd1) begin
            fails++;
            $display("FAIL accept_at_capt: got valid/ovr %b data %0d expected 10 data 1", {res_valid, overrun}, res_data);
        end
    endtask

    task automatic test_overrun();
        res_ready = 1'b0;
        mod_bit   = 1'b1;
        do_start(16'd2);
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_early: got %b expected 0", overrun);
        end
        tick();
        tests++;
        if ({res_valid, overrun} !== 2'b11 || res_data !== 32'd3) begin
            fails++;
            $display("FAIL overrun_set: got valid/ovr %b data %0d expected 11 data 3", {res_valid, overrun}, res_data);
        end
        res_ready = 1'b1;
        tick();
        tick();
        tests++;
        if ({res_valid, overrun} !== 2'b01) begin
            fails++;
            $display("FAIL overrun_sticky: got valid/ovr %b expected 01", {res_valid, overrun});
        end
    endtask

    task automatic test_osr256();
        int n;
        res_ready = 1'b1;
        mod_bit   = 1'b1;
        do_start(16'd256);
        n = 0;
        while (busy && n < 400) begin
            n++;
            tick();
        end
        tests++;
        if (n !== 259) begin
            fails++;
            $display("FAIL osr256_busy_len: got %0d expected 259", n);
        end
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'd32896) begin
            fails++;
            $display("FAIL osr256_result: got valid %b data %0d expected valid 1 data 32896", res_valid, res_data);
        end
        tick();
        mod_bit = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        mod_bit   = 1'b1;
        do_start(16'd8);
        tick();
        tick();
        tick();
        tests++;
        if ({busy, flt_clr} !== 2'b10) begin
            fails++;
            $display("FAIL midrst_integ: got %b expected 10", {busy, flt_clr});
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({flt_clr, flt_din, busy, res_valid, overrun} !== 5'b10000 || res_data !== '0) begin
            fails++;
            $display("FAIL midrst_values: got %b data %0d expected 10000 data 0",
                     {flt_clr, flt_din, busy, res_valid, overrun}, res_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        test_1010(1'b0, "after_rst");
    endtask

`ifdef COI2_CTRL_CONT_EN
    task automatic test_cont();
        cont      = 1'b1;
        res_ready = 1'b0;
        mod_bit   = 1'b1;
        do_start(16'd8);
        for (int i = 0; i < 11; i++) tick();
        tests++;
        if ({busy, res_valid, overrun} !== 3'b110 || res_data !== 32'd36) begin
            fails++;
            $display("FAIL cont_first: got busy/valid/ovr %b data %0d expected 110 data 36", {busy, res_valid, overrun}, res_data);
        end
        mod_bit = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if ({res_valid, overrun} !== 2'b10 || res_data !== 32'd36) begin
            fails++;
            $display("FAIL cont_held: got valid/ovr %b data %0d expected 10 data 36", {res_valid, overrun}, res_data);
        end
        tick();
        tests++;
        if ({res_valid, overrun} !== 2'b11 || res_data !== 32'd0) begin
            fails++;
            $display("FAIL cont_overrun: got valid/ovr %b data %0d expected 11 data 0", {res_valid, overrun}, res_data);
        end
        mod_bit   = 1'b1;
        res_ready = 1'b1;
        tick();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL cont_drop_c24: got %b expected 0", res_valid);
        end
        for (int i = 0; i < 9; i++) tick();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL cont_low_c33: got %b expected 0", res_valid);
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'd36) begin
            fails++;
            $display("FAIL cont_third_c34: got valid %b data %0d expected valid 1 data 36", res_valid, res_data);
        end
        tick();
        cont = 1'b0;
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL cont_drop_c35: got %b expected 0", res_valid);
        end
        for (int i = 0; i < 9; i++) tick();
        tests++;
        if ({busy, res_valid} !== 2'b10) begin
            fails++;
            $display("FAIL cont_capt_c44: got %b expected 10", {busy, res_valid});
        end
        tick();
        tests++;
        if ({busy, res_valid} !== 2'b01 || res_data !== 32'd36) begin
            fails++;
            $display("FAIL cont_stop_c45: got busy/valid %b data %0d expected 01 data 36", {busy, res_valid}, res_data);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_1010(1'b0, "basic");
        test_1010(1'b1, "start_ignored");
        test_osr_zero();
        test_accept_at_capt();
        test_overrun();
        test_osr256();
        test_reset_mid();
`ifdef COI2_CTRL_CONT_EN
        test_cont();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
